// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and default datapath width for the ALU and address paths
package alu_pkg;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   DEF_WIDTH = 32;
endpackage

// File: rtl/adder_seg.sv
// adder_seg: combinational SEG-bit ripple-carry segment that also exposes the carry into its MSB
module adder_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);
    logic [SEG:0] c;
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign sum  = a ^ b ^ c[SEG-1:0];
    assign cout = c[SEG];
    assign cmsb = c[SEG-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES registered carry segments with valid/ready flow control
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    logic en;
    logic ovf_r, zero_r;
    logic unused;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0] ai, bi, si, sn, a_r, b_r, s_r;
        logic             vi, ci, co, cm, v_r, c_r;
        logic [SEG-1:0]   ss;
        logic             unused_in;
        if (k == 0) begin : g_src
            assign vi = in_valid;
            assign ai = a;
            assign bi = op == OP_SUB ? ~b : b;
            assign ci = op == OP_ADD ? cin : ~cin;
            assign si = '0;
        end else begin : g_src
            assign vi = g_st[k-1].v_r;
            assign ai = g_st[k-1].a_r;
            assign bi = g_st[k-1].b_r;
            assign ci = g_st[k-1].c_r;
            assign si = g_st[k-1].s_r;
        end
        adder_seg #(.SEG(SEG)) u_seg (
            .a   (ai[k*SEG +: SEG]),
            .b   (bi[k*SEG +: SEG]),
            .cin (ci),
            .sum (ss),
            .cout(co),
            .cmsb(cm)
        );
        always_comb begin
            sn               = si;
            sn[k*SEG +: SEG] = ss;
        end
        // data registers only load real beats so outputs keep the last result across bubbles
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
                c_r <= 1'b0;
            end else if (en) begin
                v_r <= vi;
                if (vi) begin
                    a_r <= ai;
                    b_r <= bi;
                    s_r <= sn;
                    c_r <= co;
                end
            end
        end
        assign unused_in = ^{ai, bi, cm};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (en && g_st[LAST].vi) begin
            ovf_r  <= g_st[LAST].cm ^ g_st[LAST].co;
            zero_r <= ~|g_st[LAST].sn;
        end
    end
    assign out_valid = g_st[LAST].v_r;
    assign sum       = g_st[LAST].s_r;
    assign cout      = g_st[LAST].c_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign unused    = ^{g_st[LAST].a_r, g_st[LAST].b_r};
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for three adder configurations (STAGES 4, 1, 32) against an arithmetic model
module tb_pipelined_adder;
    import alu_pkg::*;
    typedef struct {
        logic [31:0] s;
        logic        c, v, z;
        int          cyc;
        int          st;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_q = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, op = 1'b0;
    logic [2:0]  iv = '0, orr = 3'b111;
    logic        dir_en = 1'b0;
    exp_t        dir_exp;
    int          cyc = 0;
    int          checks = 0, failures = 0;
    initial forever #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, act, want);
        end
    endtask
    // signed/unsigned arithmetic in 64 bits, independent of any carry-chain structure
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic o);
        exp_t   r;
        longint sx, sy, ci, t, u;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ci = c;
        if (o == OP_SUB) begin
            t   = sx - sy - ci;
            u   = longint'(x) - longint'(y) - ci;
            r.c = u >= 0;
        end else begin
            t   = sx + sy + ci;
            u   = longint'(x) + longint'(y) + ci;
            r.c = u >= (longint'(1) << 32);
        end
        r.s   = t[31:0];
        r.v   = t > (longint'(1) << 31) - 1 || t < -(longint'(1) << 31);
        r.z   = r.s == 32'd0;
        r.cyc = 0;
        r.st  = 0;
        return r;
    endfunction
    for (genvar i = 0; i < 3; i++) begin : g_d
        localparam int S = i == 0 ? 4 : i == 1 ? 1 : 32;
        logic        ir, ov, co, of, zr;
        logic [31:0] sm;
        exp_t        q[$];
        exp_t        e;
        int          stalls = 0;
        int          pending = 0;
        bit          fresh = 1'b1;
        pipelined_adder #(.WIDTH(32), .STAGES(S)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[i]),
            .in_ready (ir),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .op       (op),
            .out_valid(ov),
            .out_ready(orr[i]),
            .sum      (sm),
            .cout     (co),
            .ovf      (of),
            .zero     (zr)
        );
        always @(negedge clk) begin
            if (!rst_n || !rst_q) begin
                chk($sformatf("d%0d_reset_in_ready", i), 64'(ir), 64'd1);
                if (!rst_q) chk($sformatf("d%0d_reset_state", i), {28'd0, ov, co, of, zr, sm}, 64'd0);
                q.delete();
                fresh = 1'b1;
            end else begin
                if (ov) begin
                    if (q.size() == 0) chk($sformatf("d%0d_spurious_out_valid", i), 64'(ov), 64'd0);
                    else begin
                        e = q[0];
                        if (fresh) chk($sformatf("d%0d_latency", i), 64'(cyc - e.cyc), 64'(S + stalls - e.st));
                        chk($sformatf("d%0d_result{c,v,z,sum}", i), {29'd0, co, of, zr, sm}, {29'd0, e.c, e.v, e.z, e.s});
                        if (orr[i]) begin
                            e     = q.pop_front();
                            fresh = 1'b1;
                        end else fresh = 1'b0;
                    end
                end
                if (iv[i] && ir) begin
                    e     = dir_en ? dir_exp : model(a, b, cin, op);
                    e.cyc = cyc;
                    e.st  = stalls;
                    q.push_back(e);
                end
                if (ov && !orr[i]) stalls++;
            end
            pending = q.size();
        end
    end
    task automatic issue(input logic [2:0] m, input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xo);
        int n = 0;
        a   = xa;
        b   = xb;
        cin = xc;
        op  = xo;
        iv  = m;
        forever begin
            @(negedge clk);
            if ((g_d[0].ir | ~m[0]) & (g_d[1].ir | ~m[1]) & (g_d[2].ir | ~m[2])) break;
            if (++n > 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic issue_d(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xo,
                           input logic [31:0] es, input logic ec, input logic ev, input logic ez);
        dir_exp = '{s: es, c: ec, v: ev, z: ez, cyc: 0, st: 0};
        dir_en  = 1'b1;
        issue(3'b001, xa, xb, xc, xo);
        dir_en  = 1'b0;
    endtask
    task automatic idle(input int n);
        iv = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        int left;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_d(32'd5, 32'd7, 1'b0, OP_ADD, 32'd12, 1'b0, 1'b0, 1'b0);
        idle(8);
        issue_d(32'hFFFF_FFFF, 32'd1, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        issue_d(32'h7FFF_FFFF, 32'd1, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        issue_d(32'd3, 32'd5, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        issue_d(32'h8000_0000, 32'd1, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        idle(8);
        fork
            begin
                repeat (16) issue(3'b001, $urandom, $urandom, 1'($urandom), 1'($urandom));
                iv = '0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 orr[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(g_d[0].ir), 64'd0);
                end
                @(posedge clk);
                #1 orr[0] = 1'b1;
            end
        join
        idle(8);
        repeat (3) issue(3'b001, $urandom, $urandom, 1'($urandom), 1'($urandom));
        iv    = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 64'(g_d[0].ov), 64'd0);
        @(posedge clk);
        #1;
        issue_d(32'd1, 32'd1, 1'b0, OP_ADD, 32'd2, 1'b0, 1'b0, 1'b0);
        idle(8);
        repeat (1000) issue(3'b111, $urandom, $urandom, 1'($urandom), 1'($urandom));
        idle(40);
        left = 100;
        while (left > 0 && g_d[0].pending + g_d[1].pending + g_d[2].pending != 0) begin
            @(posedge clk);
            left--;
        end
        chk("drain_pending", 64'(g_d[0].pending + g_d[1].pending + g_d[2].pending), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
